div_4x4: RTL and testbench

- Sequential restoring divider; the shift-subtract counterpart of the team's shift-add multiplier.
- Divides an N-bit unsigned dividend by an N-bit unsigned divisor; one quotient bit is resolved per two-cycle iteration.
- Contains its own control FSM and datapath, with a start/done handshake matching the multiplier's.
- Sits beside the multiplier in the lab arithmetic unit; driven by switch/button logic and read by display logic.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_4x4_cu.sv | 57 +++++
 rtl/div_4x4.sv | 102 ++++++++++
 tb/tb_div_4x4.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package div_pkg;
   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SUB   = 2'd2,
      FIN   = 2'd3
   } state_t;
endpackage

// File: rtl/div_4x4_cu.sv
// Control FSM for the restoring divider: sequences load, shift/subtract iterations and finish.
module div_4x4_cu
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic div_zero,
   input  logic sub_ok,
   input  logic count_done,
   output logic load,
   output logic shift,
   output logic sub_en,
   output logic cnt_up,
   output logic fin,
   output logic busy
);
   state_t state_q;
   logic   busy_q;

   // busy_q tracks state_q != IDLE, updated on the same edges as the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= div_zero ? FIN : SHIFT;
                  busy_q  <= 1'b1;
               end
            end
            SHIFT: state_q <= SUB;
            SUB: begin
               if (count_done) state_q <= FIN;
               else            state_q <= SHIFT;
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load   = (state_q == IDLE) && start;
   assign shift  = (state_q == SHIFT);
   assign cnt_up = (state_q == SUB);
   assign sub_en = cnt_up && sub_ok;
   assign fin    = (state_q == FIN);
   assign busy   = busy_q;
endmodule

// File: rtl/div_4x4.sv
// Sequential restoring divider: one quotient bit per SHIFT/SUB pair, start/done handshake.
module div_4x4
   import div_pkg::*;
#(
   parameter int N = N_DEFAULT
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);
   localparam int CNT_W = $clog2(N) + 1;

   logic [N:0]       r_q;
   logic [N-1:0]     q_q;
   logic [N-1:0]     d_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [N:0]       diff;
   logic             sub_ok;
   logic             count_done;
   logic             load, shift, sub_en, cnt_up, fin;
   logic [N-1:0]     quotient_q, remainder_q;
   logic             done_q, dbz_q;

   assign diff       = r_q - {1'b0, d_q};
   assign sub_ok     = ~diff[N];
   assign count_done = (cnt_q == CNT_W'(N - 1));
   assign cnt_d      = cnt_q + CNT_W'(1);

   div_4x4_cu u_cu (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .div_zero   (divisor == '0),
      .sub_ok     (sub_ok),
      .count_done (count_done),
      .load       (load),
      .shift      (shift),
      .sub_en     (sub_en),
      .cnt_up     (cnt_up),
      .fin        (fin),
      .busy       (busy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= '0;
         q_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         r_q   <= '0;
         q_q   <= dividend;
         d_q   <= divisor;
         cnt_q <= '0;
      end else if (shift) begin
         {r_q, q_q} <= {r_q[N-1:0], q_q, 1'b0};
      end else if (cnt_up) begin
         cnt_q <= cnt_d;
         if (sub_en) begin
            r_q    <= diff;
            q_q[0] <= 1'b1;
         end
      end
   end

   // On a zero divisor no shifts happen, so q_q still holds the captured dividend
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else if (load) begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else if (fin) begin
         done_q <= 1'b1;
         if (d_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= q_q;
            dbz_q       <= 1'b1;
         end else begin
            quotient_q  <= q_q;
            remainder_q <= r_q[N-1:0];
         end
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_4x4.sv
// Scoreboard bench for div_4x4: directed cases, random pulsed starts and a back-to-back sweep.
`timescale 1ns/1ps
module tb_div_4x4;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] dividend, divisor;
   logic [3:0] quotient, remainder;
   logic       busy, done, div_by_zero;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int z;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   done_rises = 0;
   logic done_prev = 1'b0;

   div_4x4 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input int a, input int b);
      exp_t x;
      x.a = a;
      x.b = b;
      if (b == 0) begin
         x.q = 15;
         x.r = a;
         x.z = 1;
      end else begin
         x.q = a / b;
         x.r = a % b;
         x.z = 0;
      end
      return x;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every rising done pops one expected result
   always @(negedge clk) begin
      if (rst) begin
         done_prev = 1'b0;
      end else begin
         if (done && !done_prev) begin
            done_rises++;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual_q=%0d actual_r=%0d required=no_pending_op",
                        quotient, remainder);
            end else begin
               mon_e = sb_q.pop_front();
               $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d (want q=%0d r=%0d dbz=%0d)",
                        mon_e.a, mon_e.b, quotient, remainder, div_by_zero,
                        mon_e.q, mon_e.r, mon_e.z);
               check("quotient", int'(quotient), mon_e.q);
               check("remainder", int'(remainder), mon_e.r);
               check("div_by_zero", int'(div_by_zero), mon_e.z);
               if (mon_e.b != 0) begin
                  check("invariant", int'(quotient) * mon_e.b + int'(remainder), mon_e.a);
                  check("rem_lt_div", int'(remainder < 4'(mon_e.b)), 1);
               end
            end
         end
         done_prev = done;
      end
   end

   // Issue one pulsed-start division from a negedge with busy low; returns edges to done and busy samples
   task automatic do_div(input int a, input int b, input int poke, output int lat, output int bcnt);
      int e;
      dividend = 4'(a);
      divisor  = 4'(b);
      start    = 1'b1;
      sb_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      e    = 0;
      bcnt = 0;
      lat  = -1;
      while (e <= 30) begin
         @(negedge clk);
         if (e == 0) begin
            check("done_cleared", int'(done), 0);
            check("dbz_cleared", int'(div_by_zero), 0);
         end
         if (poke > 0 && e == poke - 1) begin
            start    = 1'b1;
            dividend = 4'd7;
            divisor  = 4'd7;
         end else if (poke > 0 && e == poke) begin
            start = 1'b0;
         end
         if (busy) bcnt++;
         if (done) begin
            lat = e;
            break;
         end
         @(posedge clk);
         e++;
      end
      if (lat < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual_edges=%0d required=done_seen", e);
      end
   endtask

   task automatic run(input int a, input int b, input int poke);
      int lat, bcnt, want;
      do_div(a, b, poke, lat, bcnt);
      want = (b == 0) ? 1 : 2 * N + 1;
      check("latency", lat, want);
      check("busy_cycles", bcnt, want);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int rises0;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_dbz", int'(div_by_zero), 0);
      @(negedge clk);

      run(13, 3, 0);
      run(15, 1, 0);
      run(5, 7, 0);
      run(0, 5, 0);
      run(9, 0, 0);
      run(10, 3, 0);
      run(12, 5, 3);

      // Abort 14/4 mid-operation with an asynchronous reset between edges
      dividend = 4'd14;
      divisor  = 4'd4;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_done", int'(done), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_dbz", int'(div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", int'(done), 0);
      end
      run(14, 4, 0);

      repeat (40) begin
         int a, b;
         a = int'($urandom_range(0, 15));
         b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
         run(a, b, 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Exhaustive sweep with start held high continuously
      rises0 = done_rises;
      start  = 1'b1;
      for (int i = 0; i < 256; i++) begin
         w = 0;
         while (busy && w < 40) begin
            @(negedge clk);
            w++;
         end
         if (w >= 40) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout actual_busy=%0d required=0", busy);
         end
         if (i > 0) check("bb_done_high", int'(done), 1);
         dividend = 4'(i >> 4);
         divisor  = 4'(i & 15);
         sb_q.push_back(model(i >> 4, i & 15));
         @(posedge clk);
         @(negedge clk);
         check("bb_done_cleared", int'(done), 0);
      end
      w = 0;
      while (busy && w < 40) begin
         @(negedge clk);
         w++;
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bb_done_rises", done_rises - rises0, 256);
      check("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
